pipe_issue_ctrl: RTL and testbench
==================================

// Module: pipe_issue_ctrl
// PURPOSE
//  Issue controller in front of the 4-stage register/ALU/memory pipeline.
//  Arbitrates two instruction requesters round-robin and holds any instruction
//  whose source registers are still being written by an in-flight instruction
//  (RAW hazard scoreboard). Drives the pipeline's rs1/rs2/rd/func/addr fields
//  from registers and flags unsupported function codes.
// PARAMETERS
//  PIPE_DEPTH  3   cycles from an issue until its rd write is visible in regbank
//  CNT_W       16  width of the issue and stall counters
// PORTS
//  clk1        in   1      single clock; all state updates on posedge
//  rst         in   1      asynchronous, active-high reset
//  req_valid   in   2      per-requester instruction valid
//  req_instr0  in   24     requester 0 {rs1[23:20],rs2[19:16],rd[15:12],func[11:8],addr[7:0]}
//  req_instr1  in   24     requester 1, same packing
//  req_ready   out  2      combinational accept strobe; transfer when valid & ready
//  iss_valid   out  1      registered; issue fields below are valid this cycle
//  iss_rs1     out  4      issued source 1
//  iss_rs2     out  4      issued source 2
//  iss_rd      out  4      issued destination
//  iss_func    out  4      issued ALU function (0..13 only)
//  iss_addr    out  8      issued memory address
//  iss_src     out  1      requester index of the issued instruction
//  err_func    out  1      one-cycle pulse: accepted instr had func 14/15, dropped
//  issue_cnt   out  CNT_W  issued instructions, wraps modulo 2^CNT_W
//  stall_cnt   out  CNT_W  hazard-stall cycles, saturates at all-ones
// BEHAVIOUR
//  - Reset: all outputs 0, scoreboard empty, priority pointer = requester 0.
//    Reset asserted mid-stream discards scoreboard and any pending issue.
//  - Scoreboard: PIPE_DEPTH-entry shift register of {v, rd}; each posedge
//    shifts by one, entry 0 loaded with {1, rd} on a valid issue, else {0, x}.
//    Entry leaves after PIPE_DEPTH cycles.
//  - Hazard(i): req_valid[i] and rs1 or rs2 equals rd of any valid entry.
//    Both sources always checked regardless of func. rs == own rd is not a hazard.
//  - Eligible(i) = req_valid[i] & ~Hazard(i). Instructions with func >= 14
//    are never hazarded (nothing issues for them).
//  - Grant: preferred requester (pointer) if eligible, else the other if
//    eligible, else none. req_ready = one-hot grant, same cycle.
//  - Pointer moves to the requester not granted after any grant; unchanged
//    when no grant.
//  - Accepted instr with func <= 13: next cycle iss_valid=1, fields registered,
//    iss_src = index, issue_cnt += 1, scoreboard entry loaded. Latency 1 cycle.
//  - Accepted instr with func 14/15: req_ready still asserted, next cycle
//    err_func=1, iss_valid=0, no scoreboard entry, counters unchanged.
//  - No grant: iss_valid=0; iss_* fields hold their last values.
//  - stall_cnt += 1 in any cycle with req_valid != 0 and no grant (all valid
//    requesters hazarded); never wraps.
//  - Back-to-back dependent instrs: consumer issues PIPE_DEPTH cycles after
//    producer (PIPE_DEPTH-1 bubble cycles). WAW is allowed without a stall.
//  - Requester must hold req_instr stable while valid & ~ready.
// TESTING
//  1 Reset: rst=1 mid-traffic -> all outputs 0, next grant goes to req 0 when
//    both valid and independent.
//  2 Round-robin: both valid, independent instrs every cycle -> iss_src
//    alternates 0,1,0,1; issue_cnt = 4 after 4 cycles.
//  3 RAW stall: req0 issues rd=5; req0 next has rs1=5 -> ready low 2 cycles,
//    issues 3rd cycle after the producer; stall_cnt = 2.
//  4 Bypass: req0 hazarded on rs2=5, req1 independent -> req1 granted first,
//    req0 issued once its hazard clears.
//  5 Bad func: req1 func=15 -> accepted, err_func pulse 1 cycle, iss_valid=0,
//    issue_cnt unchanged, no stall on a later reader of its rd.
//  6 Counters: preload issue_cnt=16'hFFFF via 65535 issues -> next issue
//    wraps to 0; forced stalls hold stall_cnt at 16'hFFFF.

Source files
------------

// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl
//   Issue controller in front of the 4-stage register/ALU/memory pipeline.
//   Two requesters are arbitrated round-robin. A requester is held while one
//   of its source registers is still being written by an in-flight
//   instruction. Issued fields are registered. Unsupported function codes
//   (14/15) are accepted, dropped, and flagged.
//
// Ports
//   clk1        single clock, all state on posedge
//   rst         asynchronous active-high reset
//   req_valid   [1:0] per-requester instruction valid
//   req_instr0  [23:0] {rs1,rs2,rd,func,addr} from requester 0
//   req_instr1  [23:0] same packing, requester 1
//   req_ready   [1:0] combinational one-hot accept strobe
//   iss_valid   registered issue strobe
//   iss_rs1/iss_rs2/iss_rd/iss_func/iss_addr  issued fields (hold when idle)
//   iss_src     requester index of the issued instruction
//   err_func    one-cycle pulse for an accepted func 14/15 instruction
//   issue_cnt   [CNT_W-1:0] issued instructions, wraps
//   stall_cnt   [CNT_W-1:0] hazard-stall cycles, saturates
module pipe_issue_ctrl #(
    parameter int PIPE_DEPTH = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [23:0]      req_instr0,
    input  logic [23:0]      req_instr1,
    output logic [1:0]       req_ready,
    output logic             iss_valid,
    output logic [3:0]       iss_rs1,
    output logic [3:0]       iss_rs2,
    output logic [3:0]       iss_rd,
    output logic [3:0]       iss_func,
    output logic [7:0]       iss_addr,
    output logic             iss_src,
    output logic             err_func,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    // A write becomes visible in regbank during its final pipeline cycle, so
    // only the PIPE_DEPTH-1 younger in-flight writes can block a reader.
    // PIPE_DEPTH must be at least 2.
    localparam int SB_N = PIPE_DEPTH - 1;

    logic [SB_N-1:0] sb_vld;
    logic [3:0]      sb_rd [SB_N];
    logic            ptr;

    logic [1:0]  haz_p0;
    logic [1:0]  elig_p0;
    logic        gnt_any_p0;
    logic        gnt_idx_p0;
    logic [23:0] sel_p0;
    logic        bad_p0;
    logic        issue_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic src_busy(input logic [3:0] rs1, input logic [3:0] rs2);
        logic busy;
        busy = 1'b0;
        for (int k = 0; k < SB_N; k++) begin
            if (sb_vld[k] && (rs1 == sb_rd[k] || rs2 == sb_rd[k])) busy = 1'b1;
        end
        return busy;
    endfunction

    // ---- stage p0: hazard check, arbitration, accept strobe ----
    always_comb begin
        // Bad-func instructions never issue, so they never wait on a hazard.
        haz_p0[0] = src_busy(req_instr0[23:20], req_instr0[19:16]) & (req_instr0[11:8] < 4'd14);
        haz_p0[1] = src_busy(req_instr1[23:20], req_instr1[19:16]) & (req_instr1[11:8] < 4'd14);
        elig_p0   = req_valid & ~haz_p0;

        gnt_any_p0 = 1'b0;
        gnt_idx_p0 = 1'b0;
        if (elig_p0[ptr]) begin
            gnt_any_p0 = 1'b1;
            gnt_idx_p0 = ptr;
        end else if (elig_p0[~ptr]) begin
            gnt_any_p0 = 1'b1;
            gnt_idx_p0 = ~ptr;
        end

        req_ready = 2'b00;
        if (gnt_any_p0) req_ready[gnt_idx_p0] = 1'b1;

        sel_p0   = gnt_idx_p0 ? req_instr1 : req_instr0;
        bad_p0   = (sel_p0[11:8] >= 4'd14);
        issue_p0 = gnt_any_p0 & ~bad_p0;
    end

    // ---- stage p1: registered issue, counters, scoreboard valid bits ----
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            ptr       <= 1'b0;
            sb_vld    <= '0;
            iss_valid <= 1'b0;
            iss_rs1   <= '0;
            iss_rs2   <= '0;
            iss_rd    <= '0;
            iss_func  <= '0;
            iss_addr  <= '0;
            iss_src   <= 1'b0;
            err_func  <= 1'b0;
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            iss_valid <= issue_p0;
            err_func  <= gnt_any_p0 & bad_p0;
            if (gnt_any_p0) ptr <= ~gnt_idx_p0;
            if (issue_p0) begin
                iss_rs1   <= sel_p0[23:20];
                iss_rs2   <= sel_p0[19:16];
                iss_rd    <= sel_p0[15:12];
                iss_func  <= sel_p0[11:8];
                iss_addr  <= sel_p0[7:0];
                iss_src   <= gnt_idx_p0;
                issue_cnt <= issue_cnt + 1'b1;
            end
            if ((req_valid != 2'b00) && !gnt_any_p0) stall_cnt <= sat_inc(stall_cnt);
            for (int k = SB_N - 1; k > 0; k--) sb_vld[k] <= sb_vld[k-1];
            sb_vld[0] <= issue_p0;
        end
    end

    // Destination tags are qualified by sb_vld, so they need no reset.
    always_ff @(posedge clk1) begin
        for (int k = SB_N - 1; k > 0; k--) sb_rd[k] <= sb_rd[k-1];
        sb_rd[0] <= sel_p0[15:12];
    end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
module tb_pipe_issue_ctrl;

    localparam int PD       = 3;
    localparam int TB_CNT_W = 12;
    localparam int MASK     = (1 << TB_CNT_W) - 1;

    logic                clk1 = 1'b0;
    logic                rst  = 1'b0;
    logic [1:0]          req_valid = 2'b00;
    logic [23:0]         req_instr0 = '0;
    logic [23:0]         req_instr1 = '0;
    logic [1:0]          req_ready;
    logic                iss_valid;
    logic [3:0]          iss_rs1, iss_rs2, iss_rd, iss_func;
    logic [7:0]          iss_addr;
    logic                iss_src;
    logic                err_func;
    logic [TB_CNT_W-1:0] issue_cnt;
    logic [TB_CNT_W-1:0] stall_cnt;

    pipe_issue_ctrl #(.PIPE_DEPTH(PD), .CNT_W(TB_CNT_W)) dut (
        .clk1(clk1), .rst(rst), .req_valid(req_valid),
        .req_instr0(req_instr0), .req_instr1(req_instr1), .req_ready(req_ready),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_func(iss_func), .iss_addr(iss_addr), .iss_src(iss_src),
        .err_func(err_func), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk1 = ~clk1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a register is busy until a given cycle number.
    int         m_cyc;
    int         busy_until [16];
    int         m_ptr;
    logic       m_iss_valid, m_err, m_src;
    logic [3:0] m_rs1, m_rs2, m_rd, m_func;
    logic [7:0] m_addr;
    int         m_issue, m_stall;
    logic [1:0] obs_rdy, exp_rdy_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] mk(input int rs1, input int rs2, input int rd,
                                       input int fn, input int addr);
        return {rs1[3:0], rs2[3:0], rd[3:0], fn[3:0], addr[7:0]};
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_iss_valid = 0; m_err = 0; m_src = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_func = 0; m_addr = 0;
        m_issue = 0; m_stall = 0;
        for (int r = 0; r < 16; r++) busy_until[r] = 0;
    endtask

    task automatic check_outputs(input string ph);
        check({ph, ".iss_valid"}, iss_valid, m_iss_valid);
        check({ph, ".iss_rs1"},   iss_rs1,   m_rs1);
        check({ph, ".iss_rs2"},   iss_rs2,   m_rs2);
        check({ph, ".iss_rd"},    iss_rd,    m_rd);
        check({ph, ".iss_func"},  iss_func,  m_func);
        check({ph, ".iss_addr"},  iss_addr,  m_addr);
        check({ph, ".iss_src"},   iss_src,   m_src);
        check({ph, ".err_func"},  err_func,  m_err);
        check({ph, ".issue_cnt"}, issue_cnt, m_issue[TB_CNT_W-1:0]);
        check({ph, ".stall_cnt"}, stall_cnt, m_stall[TB_CNT_W-1:0]);
    endtask

    task automatic cycle(input string ph, input logic [1:0] v,
                         input logic [23:0] i0, input logic [23:0] i1);
        logic [1:0]  elig, erdy;
        logic [23:0] ins;
        int          g;
        @(negedge clk1);
        req_valid = v; req_instr0 = i0; req_instr1 = i1;
        #1;
        for (int i = 0; i < 2; i++) begin
            ins = (i == 1) ? i1 : i0;
            elig[i] = v[i] && ((ins[11:8] >= 4'd14) ||
                      !((m_cyc < busy_until[ins[23:20]]) || (m_cyc < busy_until[ins[19:16]])));
        end
        g = -1;
        if (elig[m_ptr]) g = m_ptr;
        else if (elig[1-m_ptr]) g = 1 - m_ptr;
        erdy = 2'b00;
        if (g >= 0) erdy[g] = 1'b1;
        obs_rdy = req_ready;
        exp_rdy_last = erdy;
        check({ph, ".req_ready"}, req_ready, erdy);
        m_iss_valid = 0; m_err = 0;
        if (g >= 0) begin
            m_ptr = 1 - g;
            ins = (g == 1) ? i1 : i0;
            if (ins[11:8] >= 4'd14) m_err = 1;
            else begin
                m_iss_valid = 1;
                {m_rs1, m_rs2, m_rd, m_func, m_addr} = ins;
                m_src = g[0];
                m_issue = (m_issue + 1) & MASK;
                busy_until[ins[15:12]] = m_cyc + PD;
            end
        end else if (v != 2'b00) begin
            if (m_stall < MASK) m_stall++;
        end
        @(posedge clk1);
        #1;
        m_cyc++;
        check_outputs(ph);
    endtask

    task automatic do_reset(input string ph);
        @(negedge clk1);
        rst = 1'b1; req_valid = 2'b00;
        #1;
        model_reset();
        check({ph, ".rst_valid"}, iss_valid, 1'b0);
        check({ph, ".rst_fields"}, {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr, iss_src, err_func}, 0);
        check({ph, ".rst_issue"}, issue_cnt, 0);
        check({ph, ".rst_stall"}, stall_cnt, 0);
        @(negedge clk1);
        rst = 1'b0;
    endtask

    logic [23:0] ind0, ind1, prod, cons, haz, bad, rdr, w, s, c0, c1;
    logic [1:0]  cv;
    int          saved;

    initial begin
        m_cyc = 0;
        model_reset();

        // reset from power-up
        do_reset("reset0");

        // round robin with independent instructions
        ind0 = mk(8, 8, 2, 1, 8'h11);
        ind1 = mk(9, 9, 3, 2, 8'h22);
        for (int i = 0; i < 4; i++) begin
            cycle("rr", 2'b11, ind0, ind1);
            check("rr.src_alt", iss_src, i % 2);
        end
        check("rr.issue_cnt4", issue_cnt, 4);

        // RAW stall: consumer of rd=5 waits two cycles
        prod = mk(8, 8, 5, 3, 8'h30);
        cons = mk(5, 8, 6, 4, 8'h31);
        cycle("raw", 2'b01, prod, ind1);
        check("raw.prod_rd", iss_rd, 5);
        cycle("raw", 2'b01, cons, ind1);
        check("raw.rdy1", obs_rdy, 2'b00);
        cycle("raw", 2'b01, cons, ind1);
        check("raw.rdy2", obs_rdy, 2'b00);
        cycle("raw", 2'b01, cons, ind1);
        check("raw.rdy3", obs_rdy, 2'b01);
        check("raw.cons_rd", iss_rd, 6);
        check("raw.stall_cnt2", stall_cnt, 2);

        // bypass: hazarded req0 lets independent req1 through
        haz = mk(8, 5, 7, 5, 8'h40);
        cycle("byp", 2'b01, prod, ind1);
        cycle("byp", 2'b11, haz, ind1);
        check("byp.rdy_req1", obs_rdy, 2'b10);
        check("byp.src1", iss_src, 1'b1);
        cycle("byp", 2'b01, haz, ind1);
        check("byp.rdy_hold", obs_rdy, 2'b00);
        cycle("byp", 2'b01, haz, ind1);
        check("byp.rdy_req0", obs_rdy, 2'b01);
        check("byp.src0", iss_src, 1'b0);

        // bad func: accepted, flagged, no scoreboard entry
        bad = mk(8, 8, 10, 15, 8'h50);
        rdr = mk(10, 8, 11, 0, 8'h51);
        saved = issue_cnt;
        cycle("bad", 2'b10, ind0, bad);
        check("bad.rdy", obs_rdy, 2'b10);
        check("bad.err", err_func, 1'b1);
        check("bad.no_issue", iss_valid, 1'b0);
        check("bad.cnt_hold", issue_cnt, saved);
        cycle("bad", 2'b01, rdr, bad);
        check("bad.reader_rdy", obs_rdy, 2'b01);
        check("bad.err_clear", err_func, 1'b0);

        // randomized traffic with requesters holding while not ready
        cv = 2'b00; c0 = '0; c1 = '0; exp_rdy_last = 2'b00;
        for (int n = 0; n < 400; n++) begin
            if (!(cv[0] && !exp_rdy_last[0])) begin
                cv[0] = 1'($urandom_range(0, 3) != 0);
                c0 = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 15), $urandom_range(0, 255));
            end
            if (!(cv[1] && !exp_rdy_last[1])) begin
                cv[1] = 1'($urandom_range(0, 3) != 0);
                c1 = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 15), $urandom_range(0, 255));
            end
            cycle("rand", cv, c0, c1);
            if (n == 200) begin
                do_reset("midrst");
                cycle("midrst", 2'b11, ind0, ind1);
                check("midrst.first_req0", obs_rdy, 2'b01);
                cv = 2'b00; exp_rdy_last = 2'b00;
            end
        end

        // issue counter wrap
        do_reset("cnt");
        w = mk(15, 15, 0, 0, 8'h77);
        for (int n = 0; n < MASK; n++) cycle("wrap", 2'b01, w, ind1);
        check("wrap.full", issue_cnt, MASK);
        cycle("wrap", 2'b01, w, ind1);
        check("wrap.zero", issue_cnt, 0);

        // stall counter saturation: self-dependent stream stalls 2 of every 3 cycles
        s = mk(1, 1, 1, 0, 8'h01);
        for (int n = 0; n < 13000; n++) begin
            cycle("sat", 2'b01, s, ind1);
            if (m_stall == MASK) break;
        end
        for (int n = 0; n < 9; n++) cycle("sat", 2'b01, s, ind1);
        check("sat.allones", stall_cnt, MASK);

        @(negedge clk1);
        req_valid = 2'b00;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
